// File: rtl/set_assoc_dcache.sv
// rtl/set_assoc_dcache.sv - N-way set-associative write-back write-allocate data cache (optional DCACHE_STATS_EN hit/miss counters)
module set_assoc_dcache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd_en,
    input  logic                  cpu_wr_en,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_mask,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BO_W   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int WO_W   = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int IDX_SH = WO_W + BO_W;
    localparam int TAG_SH = IDX_W + WO_W + BO_W;
    localparam int TAG_W  = ADDR_W - TAG_SH;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;

    // Line storage and per-set replacement state
    logic [DATA_W-1:0] data_mem [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [SETS-1:0]   valid_q  [WAYS];
    logic [SETS-1:0]   dirty_q  [WAYS];
    logic [WAY_W-1:0]  rr_q     [SETS];

    logic [1:0]        state;
    logic [WO_W-1:0]   beat;
    logic [WAY_W-1:0]  victim_way;
    logic [TAG_W-1:0]  victim_tag;
    logic              replay;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WO_W-1:0]   wo;
    logic              req;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  vic;
    logic              beat_last;
    logic              beat_done;
    logic [TAG_W-1:0]  line_tag;

    assign tag       = TAG_W'(cpu_addr >> TAG_SH);
    assign idx       = IDX_W'(cpu_addr >> IDX_SH);
    assign wo        = WO_W'(cpu_addr >> BO_W);
    assign req       = cpu_rd_en | cpu_wr_en;
    assign beat_last = (beat == WO_W'(LINE_WORDS - 1));
    assign beat_done = mem_req & mem_ack;

    // Parallel tag compare across all ways of the indexed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_mem[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        vic = rr_q[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) begin
                vic = WAY_W'(w);
            end
        end
    end

    assign cpu_rdata = data_mem[hit_way][idx][wo];
    assign stall     = (state != S_IDLE) | (req & ~hit);
    assign mem_req   = (state != S_IDLE);
    assign mem_we    = (state == S_WRITEBACK);
    assign line_tag  = (state == S_WRITEBACK) ? victim_tag : tag;

    // Beat address and write data; zero outside a burst
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (state != S_IDLE) begin
            mem_addr = (ADDR_W'(line_tag) << TAG_SH) |
                       (ADDR_W'(idx) << IDX_SH) |
                       (ADDR_W'(beat) << BO_W);
        end
        if (state == S_WRITEBACK) begin
            mem_wdata = data_mem[victim_way][idx][beat];
        end
    end

    // Miss FSM plus valid/dirty/round-robin bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            beat       <= '0;
            victim_way <= '0;
            victim_tag <= '0;
            replay     <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    replay <= 1'b0;
                    if (req && !hit) begin
                        victim_way <= vic;
                        victim_tag <= tag_mem[vic][idx];
                        beat       <= '0;
                        // The victim is dead to lookups from here on; a reset
                        // mid-refill must never expose a half-filled line.
                        valid_q[vic][idx] <= 1'b0;
                        if (valid_q[vic][idx] && dirty_q[vic][idx]) begin
                            state <= S_WRITEBACK;
                        end else begin
                            state <= S_REFILL;
                        end
                    end else if (cpu_wr_en && hit) begin
                        dirty_q[hit_way][idx] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (beat_done) begin
                        beat <= beat + 1'b1;
                        if (beat_last) begin
                            state <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (beat_done) begin
                        beat <= beat + 1'b1;
                        if (beat_last) begin
                            valid_q[victim_way][idx] <= 1'b1;
                            dirty_q[victim_way][idx] <= 1'b0;
                            rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
                            replay <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data/tag arrays: masked store hits and refill beats
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((state == S_IDLE) && cpu_wr_en && hit) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (cpu_mask[b]) begin
                        data_mem[hit_way][idx][wo][8*b +: 8] <= cpu_wdata[8*b +: 8];
                    end
                end
            end
            if ((state == S_REFILL) && beat_done) begin
                data_mem[victim_way][idx][beat] <= mem_rdata;
                if (beat_last) begin
                    tag_mem[victim_way][idx] <= tag;
                end
            end
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr;

`ifdef DCACHE_STATS_EN
    // Hit/miss counters; the replay lookup after a refill is not a hit
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == S_IDLE) && req) begin
            if (hit && !replay) begin
                hit_count <= hit_count + 32'd1;
            end else if (!hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    logic unused_replay;
    assign unused_replay = replay;
`endif

endmodule

// File: tb/tb_set_assoc_dcache.sv
// tb/tb_set_assoc_dcache.sv - randomized self-checking bench for set_assoc_dcache against a line-level reference model
module tb_set_assoc_dcache;

    localparam int LW    = 4;
    localparam int WAYS  = 2;
    localparam int SETS  = 16;
    localparam int MEMW  = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd_en, cpu_wr_en;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_mask;
    logic [31:0] cpu_rdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    set_assoc_dcache dut (
        .clk(clk), .reset(reset),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Backing memory with configurable ack wait and a beat log
    logic [31:0] backing [0:MEMW-1];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_a;
    logic [31:0] poke_d;
    int          wait_cycles = 0;
    int          wait_cnt = 0;
    int          log_n = 0;
    logic [31:0] log_addr [0:1023];
    logic [31:0] log_data [0:1023];
    logic        log_we   [0:1023];

    always_comb mem_ack = mem_req && (wait_cnt >= wait_cycles);
    always_comb mem_rdata = backing[mem_addr[9:2]];

    always @(posedge clk) begin
        if (poke_en) backing[poke_a] <= poke_d;
        if (reset) wait_cnt <= 0;
        else if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req) wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_ack) begin
            log_addr[log_n % 1024] <= mem_addr;
            log_data[log_n % 1024] <= mem_wdata;
            log_we[log_n % 1024]   <= mem_we;
            log_n <= log_n + 1;
            if (mem_we) backing[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // Reference model: architectural memory plus per-set line directory
    logic [31:0] golden [0:MEMW-1];
    logic        m_valid [WAYS][SETS];
    logic        m_dirty [WAYS][SETS];
    logic [23:0] m_tag   [WAYS][SETS];
    int          m_rr    [SETS];

    int n_vec = 0;
    int n_fail = 0;

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_tag[w][s]   = '0;
            end
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        // Dirty lines are lost: the architectural view falls back to memory.
        for (int i = 0; i < MEMW; i++) golden[i] = backing[i];
    endtask

    task automatic do_reset();
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        poke_en = 1'b1;
        poke_a  = 8'(a);
        poke_d  = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        golden[a] = d;
    endtask

    // One CPU request held until stall drops, checked against the model
    task automatic access(input logic is_wr, input logic both, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input int want_stall);
        int idx, hw, vic, exp_stall, exp_beats, cyc, n0, n, wi;
        logic exp_wb, timeout;
        logic [23:0] tg, old_tag;
        logic [31:0] exp_a, exp_d, exp_rd;
`ifdef DCACHE_STATS_EN
        logic [31:0] h0, m0;
        h0 = hit_count;
        m0 = miss_count;
`endif
        idx = int'(addr[7:4]);
        tg  = addr[31:8];
        wi  = int'(addr[9:2]);
        hw  = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][idx] && m_tag[w][idx] == tg) hw = w;
        vic = m_rr[idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!m_valid[w][idx]) vic = w;
        exp_wb  = (hw < 0) && m_valid[vic][idx] && m_dirty[vic][idx];
        old_tag = m_tag[vic][idx];
        exp_beats = (hw >= 0) ? 0 : (exp_wb ? 2 * LW : LW);
        exp_stall = (hw >= 0) ? 0 : 1 + exp_beats * (1 + wait_cycles);
        exp_rd  = golden[wi];
        n0 = log_n;

        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_mask  = mask;
        cpu_wr_en = is_wr;
        cpu_rd_en = !is_wr || both;
        cyc = 0;
        timeout = 1'b0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            if (cyc > 500) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
        end
        n_vec++;
        if (timeout) begin
            n_fail++;
            $display("FAIL stall_timeout addr=%h: stall still high after %0d cycles, required release", addr, cyc);
        end
        n_vec++;
        if (cyc !== exp_stall) begin
            n_fail++;
            $display("FAIL stall_cycles addr=%h: got %0d, expected %0d", addr, cyc, exp_stall);
        end
        if (want_stall >= 0) begin
            n_vec++;
            if (cyc !== want_stall) begin
                n_fail++;
                $display("FAIL scenario_stall addr=%h: got %0d, expected %0d", addr, cyc, want_stall);
            end
        end
        if (!is_wr) begin
            n_vec++;
            if (cpu_rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL load_data addr=%h: got %h, expected %h", addr, cpu_rdata, exp_rd);
            end
        end
        @(posedge clk); #1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;

        n = log_n - n0;
        n_vec++;
        if (n !== exp_beats) begin
            n_fail++;
            $display("FAIL beat_count addr=%h: got %0d, expected %0d", addr, n, exp_beats);
        end else begin
            for (int i = 0; i < exp_beats; i++) begin
                logic ewe;
                ewe = exp_wb && (i < LW);
                exp_a = {(ewe ? old_tag : tg), addr[7:4], 2'(i % LW), 2'b00};
                exp_d = ewe ? golden[int'(exp_a[9:2])] : 32'h0;
                n_vec++;
                if (log_addr[(n0 + i) % 1024] !== exp_a || log_we[(n0 + i) % 1024] !== ewe ||
                    (ewe && log_data[(n0 + i) % 1024] !== exp_d)) begin
                    n_fail++;
                    $display("FAIL beat%0d addr=%h: got a=%h we=%b d=%h, expected a=%h we=%b d=%h", i, addr,
                             log_addr[(n0 + i) % 1024], log_we[(n0 + i) % 1024], log_data[(n0 + i) % 1024],
                             exp_a, ewe, exp_d);
                end
            end
        end

        if (hw < 0) begin
            m_valid[vic][idx] = 1'b1;
            m_dirty[vic][idx] = 1'b0;
            m_tag[vic][idx]   = tg;
            m_rr[idx]         = (m_rr[idx] + 1) % WAYS;
            hw = vic;
        end
        if (is_wr) begin
            m_dirty[hw][idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (mask[b]) golden[wi][8*b +: 8] = wdata[8*b +: 8];
        end
`ifdef DCACHE_STATS_EN
        n_vec++;
        if (hit_count - h0 !== ((exp_stall == 0) ? 32'd1 : 32'd0) ||
            miss_count - m0 !== ((exp_stall == 0) ? 32'd0 : 32'd1)) begin
            n_fail++;
            $display("FAIL stats_delta addr=%h: got hit+%0d miss+%0d, expected hit+%0d miss+%0d", addr,
                     hit_count - h0, miss_count - m0, (exp_stall == 0), (exp_stall != 0));
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b req=%b we=%b addr=%h wdata=%h, expected all 0",
                     stall, mem_req, mem_we, mem_addr, mem_wdata);
        end
`ifdef DCACHE_STATS_EN
        n_vec++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got hit=%0d miss=%0d, expected 0 0", hit_count, miss_count);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        cpu_addr  = $urandom & 32'h3FC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (stall !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got stall=%b req=%b, expected 0 0", i, stall, mem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_scenarios();
        wait_cycles = 0;
        do_reset();
        access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 5);
        access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0);
        access(1'b1, 1'b0, 32'h104, 32'h11223344, 4'b0011, 0);
        access(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0);
        n_vec++;
        if (cpu_rdata !== 32'hAABB3344) begin
            n_fail++;
            $display("FAIL masked_store_merge: got %h, expected aabb3344", cpu_rdata);
        end
        do_reset();
        access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 5);
        access(1'b1, 1'b0, 32'h200, 32'hCAFE0001, 4'hF, 5);
        access(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 5);
        access(1'b1, 1'b0, 32'h300, 32'h5A5A5A5A, 4'hF, 0);
        access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 9);
    endtask

    task automatic test_reset_mid_burst();
        int n0, guard;
        wait_cycles = 2;
        do_reset();
        n0 = log_n;
        cpu_addr  = 32'h340;
        cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b1;
        guard = 0;
        while (log_n < n0 + 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL mid_burst_first_beat: got %0d beats, expected 1", log_n - n0);
        end
        reset = 1'b1;
        cpu_rd_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_burst_reset: got req=%b stall=%b, expected 0 0", mem_req, stall);
        end
        @(posedge clk); #1;
        model_reset();
        access(1'b0, 1'b0, 32'h340, 32'h0, 4'h0, 13);
        wait_cycles = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            logic wr, both;
            a = {22'h0, 2'($urandom), 2'h0, 2'($urandom), 2'($urandom), 2'b00};
            wr   = $urandom_range(0, 1) == 1;
            both = wr && ($urandom_range(0, 3) == 0);
            wait_cycles = $urandom_range(0, 1);
            access(wr, both, a, $urandom, 4'($urandom), -1);
            if ($urandom_range(0, 7) == 0) test_idle();
        end
        wait_cycles = 0;
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        access(1'b0, 1'b0, 32'h040, 32'h0, 4'h0, 5);
        access(1'b0, 1'b0, 32'h040, 32'h0, 4'h0, 0);
        access(1'b0, 1'b0, 32'h044, 32'h0, 4'h0, 0);
        access(1'b0, 1'b0, 32'h080, 32'h0, 4'h0, 5);
        n_vec++;
        if (miss_count !== 32'd2 || hit_count !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_sequence: got miss=%0d hit=%0d, expected 2 2", miss_count, hit_count);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_mask  = '0;
        for (int i = 0; i < MEMW; i++) poke(i, $urandom);
        poke(32'h100 >> 2, 32'hDEADBEEF);
        poke(32'h104 >> 2, 32'hAABBCCDD);
        test_reset();
        test_idle();
        test_scenarios();
        test_reset_mid_burst();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
